pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush controller for the 5-stage pipeline. Detects ID-stage RAW hazards against EXE/MEM

---
 rtl/pipeline_hazard_ctrl.sv | 101 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: RAW hazard detection, data-memory wait
// sequencing and a saturating count of stalled cycles.
module pipeline_hazard_ctrl #(
    parameter int MEM_WAIT = 6,
    parameter int REG_AW   = 5,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_two_src,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              exe_wb_en,
    input  logic              exe_mem_read,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_wb_en,
    input  logic              fwd_en,
    input  logic              branch_taken,
    input  logic              mem_req,
    output logic              if_stall,
    output logic              id_bubble,
    output logic              if_flush,
    output logic              mem_freeze,
    output logic              mem_ready,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int WAIT_W = (MEM_WAIT > 2) ? $clog2(MEM_WAIT - 1) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} mem_state_t;

    mem_state_t        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              exe_hz;
    logic              mem_hz;
    logic              hazard;
    logic              freeze_raw;

    // Register 0 is hard-wired zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
        return (a == b) && (a != '0);
    endfunction

    always_comb begin
        exe_hz = exe_wb_en & (reg_match(id_src1, exe_dest) |
                              (id_two_src & reg_match(id_src2, exe_dest)));
        mem_hz = mem_wb_en & (reg_match(id_src1, mem_dest) |
                              (id_two_src & reg_match(id_src2, mem_dest)));
        if (branch_taken)
            hazard = 1'b0;
        else if (fwd_en)
            hazard = exe_hz & exe_mem_read;
        else
            hazard = exe_hz | mem_hz;
    end

    assign freeze_raw = ((state == IDLE) && mem_req) || (state == ACCESS);

    // A frozen pipeline holds everything, so it must neither absorb a bubble nor flush.
    assign mem_freeze = ~rst & freeze_raw;
    assign if_stall   = ~rst & (hazard | freeze_raw);
    assign id_bubble  = ~rst & hazard & ~freeze_raw;
    assign if_flush   = ~rst & branch_taken & ~freeze_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_ready <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        state    <= ACCESS;
                        wait_cnt <= WAIT_W'(MEM_WAIT - 2);
                    end
                end
                ACCESS: begin
                    if (wait_cnt == '0) begin
                        state     <= DONE;
                        mem_ready <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (if_stall && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a cycle-indexed behavioural model checked every cycle,
// plus literal expectations for the hazard, freeze, reset and saturation scenarios.
module tb_pipeline_hazard_ctrl;

    localparam int MEM_WAIT = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_src1, id_src2, exe_dest, mem_dest;
    logic       id_two_src, exe_wb_en, exe_mem_read, mem_wb_en, fwd_en, branch_taken, mem_req;

    logic        if_stall, id_bubble, if_flush, mem_freeze, mem_ready;
    logic [15:0] stall_cycles;
    logic        if_stall3, id_bubble3, if_flush3, mem_freeze3, mem_ready3;
    logic [2:0]  stall_cycles3;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start = -1;
    int exp_c16 = 0;
    int exp_c3 = 0;
    bit check_en = 1'b0;
    int c0;

    pipeline_hazard_ctrl #(.MEM_WAIT(MEM_WAIT), .REG_AW(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .fwd_en(fwd_en),
        .branch_taken(branch_taken), .mem_req(mem_req), .if_stall(if_stall),
        .id_bubble(id_bubble), .if_flush(if_flush), .mem_freeze(mem_freeze),
        .mem_ready(mem_ready), .stall_cycles(stall_cycles)
    );

    pipeline_hazard_ctrl #(.MEM_WAIT(MEM_WAIT), .REG_AW(5), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .fwd_en(fwd_en),
        .branch_taken(branch_taken), .mem_req(mem_req), .if_stall(if_stall3),
        .id_bubble(id_bubble3), .if_flush(if_flush3), .mem_freeze(mem_freeze3),
        .mem_ready(mem_ready3), .stall_cycles(stall_cycles3)
    );

    always #5 clk = ~clk;

    function automatic bit m_match(input logic [4:0] a, input logic [4:0] b);
        return (a == b) && (a != 5'd0);
    endfunction

    function automatic bit m_hazard();
        bit e, m;
        e = exe_wb_en && (m_match(id_src1, exe_dest) || (id_two_src && m_match(id_src2, exe_dest)));
        m = mem_wb_en && (m_match(id_src1, mem_dest) || (id_two_src && m_match(id_src2, mem_dest)));
        if (branch_taken) return 1'b0;
        return fwd_en ? (e && exe_mem_read) : (e || m);
    endfunction

    // An access started at cycle "start" freezes cycles start..start+MEM_WAIT-1
    // and reports ready exactly at start+MEM_WAIT.
    function automatic bit m_active();
        return (start >= 0) && ((cyc - start) < MEM_WAIT);
    endfunction

    function automatic bit m_ready();
        return (start >= 0) && ((cyc - start) == MEM_WAIT);
    endfunction

    function automatic bit m_frz();
        return m_active() || (!m_ready() && mem_req);
    endfunction

    function automatic bit m_stall();
        return !rst && (m_hazard() || m_frz());
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            start   <= -1;
            exp_c16 <= 0;
            exp_c3  <= 0;
        end else begin
            if (m_stall()) begin
                exp_c16 <= (exp_c16 < 65535) ? exp_c16 + 1 : exp_c16;
                exp_c3  <= (exp_c3 < 7) ? exp_c3 + 1 : exp_c3;
            end
            if (!m_active() && !m_ready() && mem_req) start <= cyc;
        end
        cyc      <= cyc + 1;
        check_en <= 1'b1;
    end

    always @(negedge clk) begin
        if (check_en) begin
            bit hz, fr;
            hz = m_hazard();
            fr = m_frz();
            checkOutput("model if_stall",   32'(if_stall),   32'(!rst && (hz || fr)));
            checkOutput("model id_bubble",  32'(id_bubble),  32'(!rst && hz && !fr));
            checkOutput("model if_flush",   32'(if_flush),   32'(!rst && branch_taken && !fr));
            checkOutput("model mem_freeze", 32'(mem_freeze), 32'(!rst && fr));
            checkOutput("model mem_ready",  32'(mem_ready),  32'(m_ready()));
            checkOutput("model stall_cycles", 32'(stall_cycles), 32'(exp_c16));
            checkOutput("model if_stall3",  32'(if_stall3),  32'(!rst && (hz || fr)));
            checkOutput("model mem_ready3", 32'(mem_ready3), 32'(m_ready()));
            checkOutput("model stall_cycles3", 32'(stall_cycles3), 32'(exp_c3));
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [4:0] s1, input logic [4:0] s2, input logic two,
                                 input logic [4:0] ed, input logic ewb, input logic erd,
                                 input logic [4:0] md, input logic mwb, input logic fwd,
                                 input logic br, input logic req);
        id_src1 = s1; id_src2 = s2; id_two_src = two;
        exe_dest = ed; exe_wb_en = ewb; exe_mem_read = erd;
        mem_dest = md; mem_wb_en = mwb; fwd_en = fwd;
        branch_taken = br; mem_req = req;
    endtask

    initial begin
        // Reset with hazard, branch and memory request all active: everything must stay low.
        rst = 1'b1;
        applyStimulus(5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        nextCycle();
        @(negedge clk);
        checkOutput("reset if_stall", 32'(if_stall), 0);
        checkOutput("reset id_bubble", 32'(id_bubble), 0);
        checkOutput("reset if_flush", 32'(if_flush), 0);
        checkOutput("reset mem_freeze", 32'(mem_freeze), 0);
        checkOutput("reset mem_ready", 32'(mem_ready), 0);
        checkOutput("reset stall_cycles", 32'(stall_cycles), 0);

        // Load-use hazard with forwarding.
        nextCycle();
        rst = 1'b0;
        applyStimulus(5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("load-use if_stall", 32'(if_stall), 1);
        checkOutput("load-use id_bubble", 32'(id_bubble), 1);
        checkOutput("load-use if_flush", 32'(if_flush), 0);

        nextCycle();
        applyStimulus(5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("fwd no-load if_stall", 32'(if_stall), 0);

        // MEM-stage hazard on src2 without forwarding, then the register-0 and one-source cases.
        nextCycle();
        applyStimulus(5'd7, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("mem src2 if_stall", 32'(if_stall), 1);
        checkOutput("mem src2 id_bubble", 32'(id_bubble), 1);
        nextCycle();
        applyStimulus(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("reg0 if_stall", 32'(if_stall), 0);
        nextCycle();
        applyStimulus(5'd7, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("one-src if_stall", 32'(if_stall), 0);

        // Taken branch overrides a load-use hazard.
        nextCycle();
        applyStimulus(5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("branch if_flush", 32'(if_flush), 1);
        checkOutput("branch if_stall", 32'(if_stall), 0);
        checkOutput("branch id_bubble", 32'(id_bubble), 0);

        // Memory access with a concurrent EXE hazard.
        nextCycle();
        applyStimulus(5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("acc t mem_freeze", 32'(mem_freeze), 1);
        checkOutput("acc t id_bubble", 32'(id_bubble), 0);
        checkOutput("acc t mem_ready", 32'(mem_ready), 0);
        c0 = int'(stall_cycles);
        for (int k = 1; k <= 5; k++) begin
            nextCycle();
            mem_req = 1'b0;
            branch_taken = (k == 2);
            @(negedge clk);
            checkOutput("acc mem_freeze", 32'(mem_freeze), 1);
            checkOutput("acc if_stall", 32'(if_stall), 1);
            checkOutput("acc id_bubble", 32'(id_bubble), 0);
            checkOutput("acc if_flush", 32'(if_flush), 0);
            checkOutput("acc mem_ready", 32'(mem_ready), 0);
        end
        nextCycle();
        mem_req = 1'b1;
        @(negedge clk);
        checkOutput("acc t+6 mem_freeze", 32'(mem_freeze), 0);
        checkOutput("acc t+6 mem_ready", 32'(mem_ready), 1);
        checkOutput("acc t+6 id_bubble", 32'(id_bubble), 1);
        checkOutput("acc t+6 stall delta", 32'(stall_cycles), 32'(c0 + 6));
        nextCycle();
        @(negedge clk);
        checkOutput("b2b mem_freeze", 32'(mem_freeze), 1);
        checkOutput("b2b mem_ready", 32'(mem_ready), 0);

        // Reset three cycles into the second access.
        nextCycle();
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst mid mem_freeze", 32'(mem_freeze), 0);
        checkOutput("rst mid if_stall", 32'(if_stall), 0);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post-rst mem_freeze", 32'(mem_freeze), 0);
        checkOutput("post-rst if_stall", 32'(if_stall), 0);
        checkOutput("post-rst stall_cycles", 32'(stall_cycles), 0);
        for (int k = 0; k < 8; k++) begin
            checkOutput("post-rst mem_ready", 32'(mem_ready), 0);
            nextCycle();
            @(negedge clk);
        end

        // Saturation of the 3-bit counter.
        nextCycle();
        applyStimulus(5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            nextCycle();
            if (i == 3) begin
                @(negedge clk);
                checkOutput("sat partial stall_cycles3", 32'(stall_cycles3), 3);
            end
        end
        @(negedge clk);
        checkOutput("sat stall_cycles3", 32'(stall_cycles3), 7);
        checkOutput("sat stall_cycles", 32'(stall_cycles), 10);

        nextCycle();
        applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
